bmp_stream_parser: RTL and testbench



---
 rtl/bmp_stream_parser_pkg.sv | 42 ++++
 rtl/bmp_stream_parser_addr_gen.sv | 58 +++++
 rtl/bmp_stream_parser.sv | 211 +++++++++++++++++++++
 tb/tb_bmp_stream_parser.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmp_stream_parser_pkg.sv
// rtl/bmp_stream_parser_pkg.sv - header offsets, error/status codes and parser state type
package bmp_stream_parser_pkg;

    // Byte indices of the little-endian BMP header fields
    localparam logic [31:0] OFF_SIG        = 32'd0;
    localparam logic [31:0] OFF_PIX_OFFSET = 32'd10;
    localparam logic [31:0] OFF_WIDTH      = 32'd18;
    localparam logic [31:0] OFF_HEIGHT     = 32'd22;
    localparam logic [31:0] OFF_BPP        = 32'd28;
    localparam logic [31:0] OFF_COMP       = 32'd30;
    localparam logic [31:0] HDR_LEN        = 32'd54;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_SIG    = 3'd1;
    localparam logic [2:0] ERR_BPP    = 3'd2;
    localparam logic [2:0] ERR_COMP   = 3'd3;
    localparam logic [2:0] ERR_WIDTH  = 3'd4;
    localparam logic [2:0] ERR_HEIGHT = 3'd5;
    localparam logic [2:0] ERR_OFFSET = 3'd6;

    // Codes shown on the 7-segment display
    localparam logic [3:0] STAT_IDLE    = 4'h0;
    localparam logic [3:0] STAT_HEADER  = 4'h2;
    localparam logic [3:0] STAT_LOADING = 4'h3;
    localparam logic [3:0] STAT_DONE    = 4'h4;
    localparam logic [3:0] STAT_ERROR   = 4'hE;

    typedef enum logic [2:0] {
        S_HDR,
        S_SKIP,
        S_PIXEL,
        S_PAD,
        S_DONE,
        S_ERR
    } state_t;

    // Magnitude of a two's complement header field
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/bmp_stream_parser_addr_gen.sv
// rtl/bmp_stream_parser_addr_gen.sv - column/row counters and framebuffer row base stepping
module bmp_addr_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pixel_strobe,
    input  logic [11:0]           width,
    input  logic [11:0]           height,
    input  logic                  bottom_up,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  row_end,
    output logic                  last_pixel
);

    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(H_ACTIVE);

    logic [11:0]           r_col;
    logic [11:0]           r_row;
    logic [11:0]           r_width;
    logic [11:0]           r_height;
    logic                  r_bottom_up;
    logic [ADDR_WIDTH-1:0] r_row_base;

    // Latch geometry on start, then advance one pixel per strobe, wrapping rows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_width     <= '0;
            r_height    <= '0;
            r_bottom_up <= 1'b0;
            r_row_base  <= '0;
        end else if (start) begin
            r_col       <= '0;
            r_row       <= '0;
            r_width     <= width;
            r_height    <= height;
            r_bottom_up <= bottom_up;
            r_row_base  <= bottom_up ? ADDR_WIDTH'(height - 12'd1) * STRIDE : '0;
        end else if (pixel_strobe) begin
            if (row_end) begin
                r_col      <= '0;
                r_row      <= r_row + 12'd1;
                r_row_base <= r_bottom_up ? (r_row_base - STRIDE) : (r_row_base + STRIDE);
            end else begin
                r_col <= r_col + 12'd1;
            end
        end
    end

    assign row_end    = (r_col == r_width - 12'd1);
    assign last_pixel = row_end && (r_row == r_height - 12'd1);
    assign addr       = r_row_base + ADDR_WIDTH'(r_col);

endmodule

// File: rtl/bmp_stream_parser.sv
// rtl/bmp_stream_parser.sv - BMP header check and 24-bit pixel unpacking into framebuffer writes
module bmp_stream_parser
    import bmp_stream_parser_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [23:0]           wr_data,
    output logic [11:0]           img_width,
    output logic [11:0]           img_height,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            err_code,
    output logic [3:0]            status
);

    state_t                r_state;
    logic [31:0]           r_cnt;
    logic                  r_sig_ok;
    logic [31:0]           r_offset;
    logic [31:0]           r_width;
    logic [31:0]           r_height;
    logic [15:0]           r_bpp;
    logic [31:0]           r_comp;
    logic [1:0]            r_phase;
    logic [7:0]            r_b;
    logic [7:0]            r_g;
    logic [1:0]            r_pad;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [23:0]           r_wr_data;
    logic [11:0]           r_img_w;
    logic [11:0]           r_img_h;
    logic                  r_done;
    logic                  r_error;
    logic [2:0]            r_err_code;
    logic [3:0]            r_status;

    logic [31:0]           w_abs_h;
    logic [2:0]            w_err;
    logic                  w_start;
    logic                  w_pix_strobe;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_row_end;
    logic                  w_last_pixel;

    assign w_abs_h = abs32(r_height);

    // Header checks in priority order; all fields are settled before byte 53 arrives
    always_comb begin
        w_err = ERR_NONE;
        if (!r_sig_ok)
            w_err = ERR_SIG;
        else if (r_bpp != 16'd24)
            w_err = ERR_BPP;
        else if (r_comp != 32'd0)
            w_err = ERR_COMP;
        else if (r_width == 32'd0 || r_width > 32'(H_ACTIVE))
            w_err = ERR_WIDTH;
        else if (w_abs_h == 32'd0 || w_abs_h > 32'(V_ACTIVE))
            w_err = ERR_HEIGHT;
        else if (r_offset < HDR_LEN)
            w_err = ERR_OFFSET;
    end

    assign w_start      = (r_state == S_HDR) && in_valid && (r_cnt == HDR_LEN - 32'd1) && (w_err == ERR_NONE);
    assign w_pix_strobe = (r_state == S_PIXEL) && in_valid && (r_phase == 2'd2);

    bmp_addr_gen #(
        .H_ACTIVE   (H_ACTIVE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .start        (w_start),
        .pixel_strobe (w_pix_strobe),
        .width        (r_width[11:0]),
        .height       (w_abs_h[11:0]),
        .bottom_up    (~r_height[31]),
        .addr         (w_addr),
        .row_end      (w_row_end),
        .last_pixel   (w_last_pixel)
    );

    // Parser FSM: header capture, offset skip, BGR unpack, row padding, sticky end states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_HDR;
            r_cnt      <= '0;
            r_sig_ok   <= 1'b0;
            r_offset   <= '0;
            r_width    <= '0;
            r_height   <= '0;
            r_bpp      <= '0;
            r_comp     <= '0;
            r_phase    <= '0;
            r_b        <= '0;
            r_g        <= '0;
            r_pad      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_img_w    <= '0;
            r_img_h    <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_status   <= STAT_IDLE;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_HDR: if (in_valid) begin
                    r_cnt    <= r_cnt + 32'd1;
                    r_status <= STAT_HEADER;
                    case (r_cnt)
                        OFF_SIG:                r_sig_ok <= (in_byte == 8'h42);
                        OFF_SIG + 32'd1:        r_sig_ok <= r_sig_ok && (in_byte == 8'h4D);
                        OFF_PIX_OFFSET:         r_offset[7:0]   <= in_byte;
                        OFF_PIX_OFFSET + 32'd1: r_offset[15:8]  <= in_byte;
                        OFF_PIX_OFFSET + 32'd2: r_offset[23:16] <= in_byte;
                        OFF_PIX_OFFSET + 32'd3: r_offset[31:24] <= in_byte;
                        OFF_WIDTH:              r_width[7:0]    <= in_byte;
                        OFF_WIDTH + 32'd1:      r_width[15:8]   <= in_byte;
                        OFF_WIDTH + 32'd2:      r_width[23:16]  <= in_byte;
                        OFF_WIDTH + 32'd3:      r_width[31:24]  <= in_byte;
                        OFF_HEIGHT:             r_height[7:0]   <= in_byte;
                        OFF_HEIGHT + 32'd1:     r_height[15:8]  <= in_byte;
                        OFF_HEIGHT + 32'd2:     r_height[23:16] <= in_byte;
                        OFF_HEIGHT + 32'd3:     r_height[31:24] <= in_byte;
                        OFF_BPP:                r_bpp[7:0]      <= in_byte;
                        OFF_BPP + 32'd1:        r_bpp[15:8]     <= in_byte;
                        OFF_COMP:               r_comp[7:0]     <= in_byte;
                        OFF_COMP + 32'd1:       r_comp[15:8]    <= in_byte;
                        OFF_COMP + 32'd2:       r_comp[23:16]   <= in_byte;
                        OFF_COMP + 32'd3:       r_comp[31:24]   <= in_byte;
                        HDR_LEN - 32'd1: begin
                            if (w_err != ERR_NONE) begin
                                r_state    <= S_ERR;
                                r_error    <= 1'b1;
                                r_err_code <= w_err;
                                r_status   <= STAT_ERROR;
                            end else begin
                                r_state  <= (r_offset == HDR_LEN) ? S_PIXEL : S_SKIP;
                                r_status <= STAT_LOADING;
                                r_img_w  <= r_width[11:0];
                                r_img_h  <= w_abs_h[11:0];
                                r_phase  <= 2'd0;
                            end
                        end
                        default: ;
                    endcase
                end
                S_SKIP: if (in_valid) begin
                    r_cnt <= r_cnt + 32'd1;
                    if (r_cnt == r_offset - 32'd1)
                        r_state <= S_PIXEL;
                end
                S_PIXEL: if (in_valid) begin
                    case (r_phase)
                        2'd0: begin
                            r_b     <= in_byte;
                            r_phase <= 2'd1;
                        end
                        2'd1: begin
                            r_g     <= in_byte;
                            r_phase <= 2'd2;
                        end
                        default: begin
                            r_phase   <= 2'd0;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_addr;
                            r_wr_data <= {in_byte, r_g, r_b};
                            if (w_last_pixel) begin
                                r_state  <= S_DONE;
                                r_done   <= 1'b1;
                                r_status <= STAT_DONE;
                            end else if (w_row_end && r_width[1:0] != 2'd0) begin
                                r_state <= S_PAD;
                                r_pad   <= r_width[1:0];
                            end
                        end
                    endcase
                end
                S_PAD: if (in_valid) begin
                    r_pad <= r_pad - 2'd1;
                    if (r_pad == 2'd1)
                        r_state <= S_PIXEL;
                end
                default: ;
            endcase
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign img_width  = r_img_w;
    assign img_height = r_img_h;
    assign done       = r_done;
    assign error      = r_error;
    assign err_code   = r_err_code;
    assign status     = r_status;

endmodule

// File: tb/tb_bmp_stream_parser.sv
// tb/tb_bmp_stream_parser.sv - scoreboard bench for bmp_stream_parser
module tb_bmp_stream_parser;

    typedef struct {
        logic [18:0] addr;
        logic [23:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [23:0] wr_data;
    logic [11:0] img_width;
    logic [11:0] img_height;
    logic        done;
    logic        error;
    logic [2:0]  err_code;
    logic [3:0]  status;

    int n_vec  = 0;
    int n_miss = 0;
    int n_wr   = 0;

    wr_t        sb[$];
    wr_t        exp_l[$];
    logic [7:0] fbytes[$];
    bit         fr[$];

    bmp_stream_parser dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .img_width  (img_width),
        .img_height (img_height),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .status     (status)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Monitor: every framebuffer write must match the oldest outstanding expectation
    always @(negedge clk) begin
        wr_t e;
        if (!rst && wr_en) begin
            n_wr++;
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_write: got addr %0d data %06h, expected no write", wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    n_miss++;
                    $display("FAIL write: got addr %0d data %06h, expected addr %0d data %06h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int model_err(input logic [7:0] sig1, input int bpp, input int comp,
                                     input int w, input int h, input int off);
        if (sig1 != 8'h4D)              return 1;
        if (bpp != 24)                  return 2;
        if (comp != 0)                  return 3;
        if (w < 1 || w > 640)           return 4;
        if (iabs(h) < 1 || iabs(h) > 480) return 5;
        if (off < 54)                   return 6;
        return 0;
    endfunction

    // Reference: lay out a BMP file and list the framebuffer writes it should cause
    task automatic build(input int w, input int h, input int off, input logic [7:0] sig1,
                         input int bpp, input int comp, input bit pat);
        logic [7:0] hdr [0:53];
        logic [7:0] b, g, r;
        int absh, drow, pix, pad;
        fbytes.delete();
        fr.delete();
        exp_l.delete();
        for (int k = 0; k < 54; k++) hdr[k] = 8'h00;
        hdr[0] = 8'h42;
        hdr[1] = sig1;
        hdr[14] = 8'd40;
        hdr[26] = 8'd1;
        for (int k = 0; k < 4; k++) begin
            hdr[10 + k] = 8'(off >> (8 * k));
            hdr[18 + k] = 8'(w >> (8 * k));
            hdr[22 + k] = 8'(h >> (8 * k));
            hdr[30 + k] = 8'(comp >> (8 * k));
        end
        hdr[28] = 8'(bpp);
        hdr[29] = 8'(bpp >> 8);
        for (int k = 0; k < 54; k++) begin
            fbytes.push_back(hdr[k]);
            fr.push_back(1'b0);
        end
        for (int k = 54; k < off; k++) begin
            fbytes.push_back(8'($urandom));
            fr.push_back(1'b0);
        end
        if (model_err(sig1, bpp, comp, w, h, off) != 0) begin
            for (int k = 0; k < 30; k++) begin
                fbytes.push_back(8'($urandom));
                fr.push_back(1'b0);
            end
        end else begin
            absh = iabs(h);
            pad  = (4 - (3 * w) % 4) % 4;
            for (int row = 0; row < absh; row++) begin
                drow = (h > 0) ? (absh - 1 - row) : row;
                for (int c = 0; c < w; c++) begin
                    pix = row * w + c;
                    if (pat) begin
                        b = pix[7:0];
                        g = ~pix[7:0];
                        r = 8'h5A;
                    end else begin
                        b = 8'($urandom);
                        g = 8'($urandom);
                        r = 8'($urandom);
                    end
                    fbytes.push_back(b); fr.push_back(1'b0);
                    fbytes.push_back(g); fr.push_back(1'b0);
                    fbytes.push_back(r); fr.push_back(1'b1);
                    exp_l.push_back('{addr: 19'(drow * 640 + c), data: {r, g, b}});
                end
                for (int p = 0; p < pad; p++) begin
                    fbytes.push_back(8'($urandom));
                    fr.push_back(1'b0);
                end
            end
        end
    endtask

    // Drive the file; an expected write is queued as its R byte goes out
    task automatic send(input int stop_after, input int gap_pct, input int st_after_hdr);
        int k = 0;
        for (int i = 0; i < fbytes.size(); i++) begin
            if (stop_after > 0 && i == stop_after) break;
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i == 20) chk("status_header", status, 2);
            if (i == 54) chk("status_after_header", status, st_after_hdr);
            in_valid = 1'b1;
            in_byte  = fbytes[i];
            if (fr[i]) begin
                sb.push_back(exp_l[k]);
                k++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("writes_pending", sb.size(), 0);
        sb.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_status", status, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_img_width", img_width, 0);
        chk("rst_wr_addr", wr_addr, 0);
        rst = 1'b0;
    endtask

    task automatic run_case(input int w, input int h, input int off, input logic [7:0] sig1,
                            input int bpp, input int comp, input bit pat, input int gap);
        int e;
        do_reset();
        build(w, h, off, sig1, bpp, comp, pat);
        e = model_err(sig1, bpp, comp, w, h, off);
        n_wr = 0;
        send(0, gap, (e == 0) ? 3 : 14);
        drain();
        if (e == 0) begin
            chk("done", done, 1);
            chk("status_done", status, 4);
            chk("error_clear", error, 0);
            chk("img_width", img_width, w);
            chk("img_height", img_height, iabs(h));
            chk("write_count", n_wr, exp_l.size());
        end else begin
            chk("error_set", error, 1);
            chk("err_code", err_code, e);
            chk("status_error", status, 14);
            chk("done_clear", done, 0);
            chk("no_writes", n_wr, 0);
        end
    endtask

    initial begin
        int w, hm, h, off, gap;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Extreme heights/widths with the index pattern, bytes back-to-back
        run_case(1, 480, 54, 8'h4D, 24, 0, 1'b1, 0);
        run_case(640, 2, 54, 8'h4D, 24, 0, 1'b1, 0);
        // Top-down with 3 pad bytes per row, and a long junk gap before pixels
        run_case(3, -2, 54, 8'h4D, 24, 0, 1'b0, 0);
        run_case(5, 3, 138, 8'h4D, 24, 0, 1'b0, 0);

        // Header rejections, one per check
        run_case(4, 4, 54, 8'h4E, 24, 0, 1'b0, 0);
        run_case(4, 4, 54, 8'h4D, 32, 0, 1'b0, 0);
        run_case(4, 4, 54, 8'h4D, 24, 1, 1'b0, 0);
        run_case(641, 4, 54, 8'h4D, 24, 0, 1'b0, 0);
        run_case(0, 4, 54, 8'h4D, 24, 0, 1'b0, 0);
        run_case(4, 481, 54, 8'h4D, 24, 0, 1'b0, 0);
        run_case(4, -481, 54, 8'h4D, 24, 0, 1'b0, 0);
        run_case(4, 4, 53, 8'h4D, 24, 0, 1'b0, 0);

        // Random small images, both orientations, random offsets and idle gaps
        for (int it = 0; it < 16; it++) begin
            w   = $urandom_range(1, 9);
            hm  = $urandom_range(1, 5);
            h   = ($urandom_range(0, 1) == 1) ? hm : -hm;
            off = ($urandom_range(0, 2) == 0) ? 54 : 54 + $urandom_range(1, 40);
            gap = ($urandom_range(0, 1) == 1) ? 30 : 0;
            run_case(w, h, off, 8'h4D, 24, 0, 1'b0, gap);
        end

        // Abort mid-pixel-stream with an asynchronous reset, then load a fresh file
        do_reset();
        build(8, 8, 54, 8'h4D, 24, 0, 1'b0);
        send(100, 0, 3);
        drain();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_status", status, 0);
        chk("async_img_width", img_width, 0);
        chk("async_wr_addr", wr_addr, 0);
        chk("async_wr_data", wr_data, 0);
        chk("async_done", done, 0);
        chk("async_error", error, 0);
        @(negedge clk);
        rst = 1'b0;
        build(4, 4, 54, 8'h4D, 24, 0, 1'b0);
        n_wr = 0;
        send(0, 0, 3);
        drain();
        chk("restart_done", done, 1);
        chk("restart_status", status, 4);
        chk("restart_writes", n_wr, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
